match_pair_tx: RTL and testbench



---
 rtl/match_pair_tx.sv | 163 ++++++++++++++++
 tb/tb_match_pair_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_pair_tx.sv
// Output stage of the matcher: buffers matched pairs in a first-word fall-through FIFO,
// streams them out over valid/ready, tags each frame's last pair and reports per-frame counts.
module match_pair_tx #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [9:0]       i_src_coor_x,
    input  logic [9:0]       i_src_coor_y,
    input  logic [9:0]       i_dst_coor_x,
    input  logic [9:0]       i_dst_coor_y,
    input  logic             i_end,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [39:0]      o_pair,
    output logic             o_last,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0]    OCC_ONE  = OW'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [39:0]       mem [DEPTH];

    logic valid;
    logic full;
    logic pop;
    logic wr;
    logic drop;
    logic frame_start;
    logic last_here;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign full        = (occ_q == OCC_FULL);
    assign valid       = (occ_q != '0) && (state_q != S_DONE);
    assign pop         = valid && i_ready;
    assign wr          = i_valid && !full && ((state_q == S_IDLE) || (state_q == S_COLLECT));
    assign drop        = i_valid && !wr;
    assign frame_start = (state_q == S_IDLE) && (i_valid || i_end);

    // An i_end with no new pair makes the single buffered pair final; tag it before it can leave untagged.
    assign last_here = (state_q == S_DRAIN) ||
                       ((state_q == S_COLLECT) && i_end && !i_valid);

    assign o_valid      = valid;
    assign o_pair       = valid ? mem[rd_ptr_q] : '0;
    assign o_last       = valid && (occ_q == OCC_ONE) && last_here;
    assign o_frame_done = (state_q == S_DONE);
    assign o_match_cnt  = match_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_full       = full;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !wr) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_comb begin
        match_cnt_d = match_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (frame_start) begin
            match_cnt_d = '0;
            drop_cnt_d  = '0;
        end
        if (wr) begin
            match_cnt_d = match_cnt_d + CNT_ONE;
        end
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_d);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_end) begin
                    state_d = S_DRAIN;
                end else if (i_valid) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((occ_q == '0) || ((occ_q == OCC_ONE) && pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            match_cnt_q <= match_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Pair storage carries no reset; validity comes entirely from the occupancy count.
    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= {i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y};
        end
    end

endmodule

// File: tb/tb_match_pair_tx.sv
// Randomised and directed bench for match_pair_tx: a frame-level reference model feeds a
// scoreboard queue that a negedge monitor drains whenever the DUT hands over a pair.
module tb_match_pair_tx;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [39:0] pair;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic [39:0]      in_pair;
    logic             i_end;
    logic             i_ready;
    logic             o_valid;
    logic [39:0]      o_pair;
    logic             o_last;
    logic             o_frame_done;
    logic [CNT_W-1:0] o_match_cnt;
    logic [CNT_W-1:0] o_drop_cnt;
    logic             o_full;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc = 0;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] m_match = '0;
    logic [CNT_W-1:0] m_drop  = '0;
    bit               accepting = 1'b1;
    bit               started   = 1'b0;
    bit               done_expected = 1'b0;
    int               wr_now = 0;

    match_pair_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_src_coor_x (in_pair[39:30]),
        .i_src_coor_y (in_pair[29:20]),
        .i_dst_coor_x (in_pair[19:10]),
        .i_dst_coor_y (in_pair[9:0]),
        .i_end        (i_end),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pair       (o_pair),
        .o_last       (o_last),
        .o_frame_done (o_frame_done),
        .o_match_cnt  (o_match_cnt),
        .o_drop_cnt   (o_drop_cnt),
        .o_full       (o_full)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] rand_pair();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    // Drive one cycle of stimulus and advance the frame-level model.
    task automatic step(input logic v, input logic [39:0] p, input logic e, input logic r);
        exp_t ne;
        exp_t t;
        @(posedge clk);
        #1;
        i_valid = v;
        in_pair = p;
        i_end   = e;
        i_ready = r;
        wr_now  = 0;
        if (accepting && !started && (v || e)) begin
            m_match = '0;
            m_drop  = '0;
            started = 1'b1;
        end
        if (v) begin
            if (accepting && exp_q.size() < DEPTH) begin
                ne.pair = p;
                ne.last = e;
                exp_q.push_back(ne);
                wr_now = 1;
                m_match++;
            end else if (m_drop != '1) begin
                m_drop++;
            end
        end
        if (e && accepting) begin
            if (wr_now == 0 && exp_q.size() > 0) begin
                t = exp_q[exp_q.size()-1];
                t.last = 1'b1;
                exp_q[exp_q.size()-1] = t;
            end
            accepting     = 1'b0;
            done_expected = 1'b1;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_expected && n < 300) begin
            step(1'b0, '0, 1'b0, $urandom_range(0, 3) != 0);
            n++;
        end
        if (done_expected) begin
            check("frame_done_timeout", 64'(done_expected), 64'(0));
            done_expected = 1'b0;
            accepting     = 1'b1;
            started       = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'(0));
        check({tag, "_pair"}, 64'(o_pair), 64'(0));
        check({tag, "_last"}, 64'(o_last), 64'(0));
        check({tag, "_done"}, 64'(o_frame_done), 64'(0));
        check({tag, "_match"}, 64'(o_match_cnt), 64'(0));
        check({tag, "_drop"}, 64'(o_drop_cnt), 64'(0));
        check({tag, "_full"}, 64'(o_full), 64'(0));
    endtask

    // Monitor: compares every handshake and frame-done against the scoreboard.
    initial begin
        bit          stall_prev;
        logic [39:0] prev_pair;
        int          exp_occ;
        exp_t        e;
        stall_prev = 1'b0;
        prev_pair  = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                stall_prev = 1'b0;
            end else begin
                exp_occ = exp_q.size() - wr_now;
                check("o_valid", 64'(o_valid), 64'(exp_occ != 0));
                check("o_full", 64'(o_full), 64'(exp_occ == DEPTH));
                if (stall_prev) begin
                    check("hold_pair", 64'(o_pair), 64'(prev_pair));
                end
                if (o_valid && i_ready && exp_occ > 0) begin
                    e = exp_q.pop_front();
                    check("pair", 64'(o_pair), 64'(e.pair));
                    check("last", 64'(o_last), 64'(e.last));
                end
                if (o_frame_done) begin
                    check("done_expected", 64'(done_expected), 64'(1));
                    check("match_cnt", 64'(o_match_cnt), 64'(m_match));
                    check("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
                    check("drained", 64'(exp_q.size()), 64'(0));
                    done_cyc      = cyc;
                    done_expected = 1'b0;
                    accepting     = 1'b1;
                    started       = 1'b0;
                end
                stall_prev = o_valid && !i_ready;
                prev_pair  = o_pair;
            end
        end
    end

    initial begin
        int t_end;
        int n;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        in_pair = '0;
        i_end   = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        i_rst = 1'b0;

        // Three pairs then i_end, downstream always ready.
        step(1'b1, {10'd1, 10'd2, 10'd3, 10'd4}, 1'b0, 1'b1);
        step(1'b1, {10'd5, 10'd6, 10'd7, 10'd8}, 1'b0, 1'b1);
        step(1'b1, {10'd9, 10'd10, 10'd11, 10'd12}, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        wait_done();
        check("t1_match", 64'(o_match_cnt), 64'(3));
        check("t1_drop", 64'(o_drop_cnt), 64'(0));

        // Overfill while stalled, then release.
        for (int k = 0; k < 6; k++) step(1'b1, rand_pair(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t2_full", 64'(o_full), 64'(1));
        wait_done();
        check("t2_match", 64'(o_match_cnt), 64'(4));
        check("t2_drop", 64'(o_drop_cnt), 64'(2));

        // Empty frame: i_end alone.
        step(1'b0, '0, 1'b1, 1'b1);
        t_end = cyc;
        wait_done();
        check("t3_done_cycle", 64'(done_cyc - t_end), 64'(2));
        check("t3_match", 64'(o_match_cnt), 64'(0));
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        check("hold_match", 64'(o_match_cnt), 64'(m_match));
        check("hold_drop", 64'(o_drop_cnt), 64'(m_drop));

        // Single pair together with i_end.
        step(1'b1, rand_pair(), 1'b1, 1'b1);
        wait_done();
        check("t4_match", 64'(o_match_cnt), 64'(1));

        // Full FIFO, pop and write in the same cycle: write is dropped.
        for (int k = 0; k < DEPTH; k++) step(1'b1, rand_pair(), 1'b0, 1'b0);
        step(1'b1, rand_pair(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t5_not_full", 64'(o_full), 64'(0));
        step(1'b0, '0, 1'b1, 1'b1);
        wait_done();
        check("t5_match", 64'(o_match_cnt), 64'(DEPTH));
        check("t5_drop", 64'(o_drop_cnt), 64'(1));

        // Drop counter saturates; match counter wraps.
        for (int k = 0; k < DEPTH + 20; k++) step(1'b1, rand_pair(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        wait_done();
        check("sat_drop", 64'(o_drop_cnt), 64'((1 << CNT_W) - 1));
        for (int k = 0; k < 18; k++) step(1'b1, rand_pair(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        wait_done();
        check("wrap_match", 64'(o_match_cnt), 64'(18 % (1 << CNT_W)));

        // Asynchronous reset in the middle of a drain.
        step(1'b1, rand_pair(), 1'b0, 1'b0);
        step(1'b1, rand_pair(), 1'b0, 1'b0);
        step(1'b1, rand_pair(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #3;
        i_rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        exp_q.delete();
        accepting     = 1'b1;
        started       = 1'b0;
        done_expected = 1'b0;
        wr_now        = 0;
        step(1'b0, '0, 1'b0, 1'b0);
        i_rst = 1'b0;
        step(1'b1, {10'd100, 10'd200, 10'd300, 10'd400}, 1'b1, 1'b1);
        wait_done();
        check("t6_match", 64'(o_match_cnt), 64'(1));

        // Random frames with random stalls and occasional protocol-error pairs in DRAIN.
        for (int f = 0; f < 40; f++) begin
            int stall_bias;
            n = $urandom_range(0, 12);
            stall_bias = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                step($urandom_range(0, 2) != 0, rand_pair(), 1'b0, $urandom_range(0, 3) >= stall_bias);
            end
            step($urandom_range(0, 1) != 0, rand_pair(), 1'b1, $urandom_range(0, 3) >= stall_bias);
            step($urandom_range(0, 3) == 0, rand_pair(), 1'b0, $urandom_range(0, 1) != 0);
            wait_done();
            if ($urandom_range(0, 1) != 0) step(1'b0, '0, 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
